// File: rtl/ctrl_pkg.sv
// Purpose : shared control-bundle layout for decoder, hazard unit and control pipeline.
// Contents: bundle width, field bit offsets, and the NOP bundle written on any bubble.
// Bundle  : {Jump, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}
package ctrl_pkg;

  localparam int CTRL_CW = 9;

  // Field offsets (LSB position of each field in the bundle)
  localparam int CTRL_REGWRITE_BIT = 0;
  localparam int CTRL_ALUSRC_BIT   = 1;
  localparam int CTRL_MEMWRITE_BIT = 2;
  localparam int CTRL_ALUOP_LSB    = 3;
  localparam int CTRL_ALUOP_W      = 2;
  localparam int CTRL_MEMTOREG_BIT = 5;
  localparam int CTRL_MEMREAD_BIT  = 6;
  localparam int CTRL_BRANCH_BIT   = 7;
  localparam int CTRL_JUMP_BIT     = 8;

  localparam logic [CTRL_CW-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// Purpose : one control pipeline stage, CW-bit bundle plus valid, with load / hold / kill.
// Latency : 1 cycle from ctrl_i/vld_i to ctrl_o/vld_o when loading.
// Ports   : kill_i (bubble, highest priority), load_i (take input), else hold current.
module ctrl_stage_reg #(
  parameter int             CW        = 9,
  parameter logic [CW-1:0]  NOP_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          kill_i,
  input  logic          load_i,
  input  logic [CW-1:0] ctrl_i,
  input  logic          vld_i,
  output logic [CW-1:0] ctrl_o,
  output logic          vld_o
);

  logic [CW-1:0] ctrl_q, ctrl_d;
  logic          vld_q, vld_d;

  // An invalid entry is always stored as NOP_VALUE, so the output never needs masking.
  always_comb begin
    ctrl_d = ctrl_q;
    vld_d  = vld_q;
    if (kill_i) begin
      ctrl_d = NOP_VALUE;
      vld_d  = 1'b0;
    end else if (load_i) begin
      ctrl_d = vld_i ? ctrl_i : NOP_VALUE;
      vld_d  = vld_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= NOP_VALUE;
      vld_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      vld_q  <= vld_d;
    end
  end

  assign ctrl_o = ctrl_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/ctrl_pipe_filter.sv
// Purpose : DEPTH-stage control pipeline (ID/EX, EX/MEM, MEM/WB ...) with stall, per-stage flush,
//           a flush-hold counter that forces stage-0 bubbles, and a saturating last-stage bubble counter.
// Ports   : ctrl_in/valid_in in; stall, flush_mask, hold_load/hold_len, cnt_clr controls;
//           ctrl_out/valid_out (stage k at [k*CW +: CW]), hold_busy, bubble_cnt out. Latency k+1 to stage k.
module ctrl_pipe_filter
  import ctrl_pkg::*;
#(
  parameter int            CW        = CTRL_CW,
  parameter int            DEPTH     = 3,
  parameter logic [CW-1:0] NOP_VALUE = '0,
  parameter int            HW        = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CW-1:0]       ctrl_in,
  input  logic                valid_in,
  input  logic                stall,
  input  logic [DEPTH-1:0]    flush_mask,
  input  logic                hold_load,
  input  logic [HW-1:0]       hold_len,
  input  logic                cnt_clr,
  output logic [DEPTH*CW-1:0] ctrl_out,
  output logic [DEPTH-1:0]    valid_out,
  output logic                hold_busy,
  output logic [15:0]         bubble_cnt
);

  logic [CW-1:0] stg_ctrl [DEPTH];
  logic          stg_vld  [DEPTH];

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          hold_busy_q;
  logic          hold_active;
  logic [15:0]   bub_cnt_q, bub_cnt_d;

  // A load with nonzero length bubbles stage 0 in the load cycle itself.
  assign hold_active = (hold_cnt_q != '0) || (hold_load && (hold_len != '0));

  // Load reloads (never accumulates); the load cycle counts as the first bubble.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (hold_load) begin
      hold_cnt_d = (hold_len != '0) ? (hold_len - 1'b1) : '0;
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - 1'b1;
    end
  end

  always_comb begin
    bub_cnt_d = bub_cnt_q;
    if (cnt_clr) begin
      bub_cnt_d = '0;
    end else if (!stg_vld[DEPTH-1] && (bub_cnt_q != 16'hFFFF)) begin
      bub_cnt_d = bub_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q  <= '0;
      hold_busy_q <= 1'b0;
      bub_cnt_q   <= '0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      hold_busy_q <= (hold_cnt_d != '0);
      bub_cnt_q   <= bub_cnt_d;
    end
  end

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_s0
        // Stage 0 holds on stall; hold-counter bubbles beat stall.
        ctrl_stage_reg #(.CW(CW), .NOP_VALUE(NOP_VALUE)) u_stage (
          .clk    (clk),
          .rst_n  (rst_n),
          .kill_i (flush_mask[0] || hold_active),
          .load_i (!stall),
          .ctrl_i (ctrl_in),
          .vld_i  (valid_in),
          .ctrl_o (stg_ctrl[0]),
          .vld_o  (stg_vld[0])
        );
      end else if (k == 1) begin : g_s1
        // Stage 1 receives the bubble created by a stage-0 stall.
        ctrl_stage_reg #(.CW(CW), .NOP_VALUE(NOP_VALUE)) u_stage (
          .clk    (clk),
          .rst_n  (rst_n),
          .kill_i (flush_mask[1] || stall),
          .load_i (1'b1),
          .ctrl_i (stg_ctrl[0]),
          .vld_i  (stg_vld[0]),
          .ctrl_o (stg_ctrl[1]),
          .vld_o  (stg_vld[1])
        );
      end else begin : g_sn
        ctrl_stage_reg #(.CW(CW), .NOP_VALUE(NOP_VALUE)) u_stage (
          .clk    (clk),
          .rst_n  (rst_n),
          .kill_i (flush_mask[k]),
          .load_i (1'b1),
          .ctrl_i (stg_ctrl[k-1]),
          .vld_i  (stg_vld[k-1]),
          .ctrl_o (stg_ctrl[k]),
          .vld_o  (stg_vld[k])
        );
      end
      assign ctrl_out[k*CW +: CW] = stg_ctrl[k];
      assign valid_out[k]         = stg_vld[k];
    end
  endgenerate

  assign hold_busy  = hold_busy_q;
  assign bubble_cnt = bub_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_filter.sv
module tb_ctrl_pipe_filter;

  localparam int CW    = 9;
  localparam int DEPTH = 3;
  localparam int HW    = 3;

  logic                clk;
  logic                rst_n;
  logic [CW-1:0]       ctrl_in;
  logic                valid_in;
  logic                stall;
  logic [DEPTH-1:0]    flush_mask;
  logic                hold_load;
  logic [HW-1:0]       hold_len;
  logic                cnt_clr;
  logic [DEPTH*CW-1:0] ctrl_out;
  logic [DEPTH-1:0]    valid_out;
  logic                hold_busy;
  logic [15:0]         bubble_cnt;

  int checks = 0;
  int errors = 0;

  ctrl_pipe_filter #(.CW(CW), .DEPTH(DEPTH), .NOP_VALUE('0), .HW(HW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl_in    (ctrl_in),
    .valid_in   (valid_in),
    .stall      (stall),
    .flush_mask (flush_mask),
    .hold_load  (hold_load),
    .hold_len   (hold_len),
    .cnt_clr    (cnt_clr),
    .ctrl_out   (ctrl_out),
    .valid_out  (valid_out),
    .hold_busy  (hold_busy),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle before the caller samples outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ctrl_in    = '0;
    valid_in   = 1'b0;
    stall      = 1'b0;
    flush_mask = '0;
    hold_load  = 1'b0;
    hold_len   = '0;
    cnt_clr    = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (DEPTH) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    checks++;
    if (ctrl_out !== 27'h0 || valid_out !== 3'b000) begin
      errors++;
      $display("FAIL reset_stages ctrl_out=%h valid_out=%b want 0 000", ctrl_out, valid_out);
    end
    checks++;
    if (hold_busy !== 1'b0 || bubble_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_counters hold_busy=%b bubble_cnt=%h want 0 0000", hold_busy, bubble_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Every edge after reset sees stage 2 invalid.
    repeat (5) step();
    checks++;
    if (bubble_cnt !== 16'd5) begin
      errors++;
      $display("FAIL bubble_count_idle bubble_cnt=%0d want 5", bubble_cnt);
    end
  endtask

  task automatic test_latency();
    drain();
    ctrl_in  = 9'h1A5;
    valid_in = 1'b1;
    step();
    checks++;
    if (ctrl_out[0 +: 9] !== 9'h1A5 || valid_out !== 3'b001) begin
      errors++;
      $display("FAIL lat_edge1 s0=%h vld=%b want 1a5 001", ctrl_out[0 +: 9], valid_out);
    end
    ctrl_in  = 9'h0FF;   // junk on an invalid cycle must not leak in
    valid_in = 1'b0;
    step();
    checks++;
    if (ctrl_out !== {9'h000, 9'h1A5, 9'h000} || valid_out !== 3'b010) begin
      errors++;
      $display("FAIL lat_edge2 ctrl_out=%h vld=%b want %h 010", ctrl_out,
               valid_out, {9'h000, 9'h1A5, 9'h000});
    end
    step();
    checks++;
    if (ctrl_out !== {9'h1A5, 9'h000, 9'h000} || valid_out !== 3'b100) begin
      errors++;
      $display("FAIL lat_edge3 ctrl_out=%h vld=%b want %h 100", ctrl_out,
               valid_out, {9'h1A5, 9'h000, 9'h000});
    end
    step();
    checks++;
    if (ctrl_out !== 27'h0 || valid_out !== 3'b000) begin
      errors++;
      $display("FAIL lat_edge4_nop ctrl_out=%h vld=%b want 0 000", ctrl_out, valid_out);
    end
  endtask

  task automatic test_reset_mid();
    drain();
    ctrl_in  = 9'h1A5;
    valid_in = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl_out !== 27'h0 || valid_out !== 3'b000 || bubble_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_async ctrl_out=%h vld=%b bubble_cnt=%h want 0 000 0",
               ctrl_out, valid_out, bubble_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ctrl_in = 9'h0C3;
    step();
    checks++;
    if (ctrl_out[0 +: 9] !== 9'h0C3 || valid_out !== 3'b001) begin
      errors++;
      $display("FAIL reset_first_load s0=%h vld=%b want 0c3 001", ctrl_out[0 +: 9], valid_out);
    end
  endtask

  task automatic test_stall();
    drain();
    ctrl_in  = 9'h0C3;
    valid_in = 1'b1;
    step();
    stall   = 1'b1;
    ctrl_in = 9'h111;
    step();
    checks++;
    if (ctrl_out !== {9'h000, 9'h000, 9'h0C3} || valid_out !== 3'b001) begin
      errors++;
      $display("FAIL stall_hold ctrl_out=%h vld=%b want %h 001", ctrl_out,
               valid_out, {9'h000, 9'h000, 9'h0C3});
    end
    stall    = 1'b0;
    valid_in = 1'b0;
    step();
    checks++;
    if (ctrl_out !== {9'h000, 9'h0C3, 9'h000} || valid_out !== 3'b010) begin
      errors++;
      $display("FAIL stall_release ctrl_out=%h vld=%b want %h 010", ctrl_out,
               valid_out, {9'h000, 9'h0C3, 9'h000});
    end
  endtask

  task automatic test_flush();
    drain();
    valid_in = 1'b1;
    ctrl_in  = 9'h055;
    step();
    ctrl_in  = 9'h0AA;
    step();
    stall      = 1'b1;
    flush_mask = 3'b011;
    ctrl_in    = 9'h1FF;
    step();
    checks++;
    if (ctrl_out !== {9'h055, 9'h000, 9'h000} || valid_out !== 3'b100) begin
      errors++;
      $display("FAIL flush_over_stall ctrl_out=%h vld=%b want %h 100", ctrl_out,
               valid_out, {9'h055, 9'h000, 9'h000});
    end
    // Last-stage-only flush: upstream keeps moving.
    stall      = 1'b0;
    flush_mask = 3'b000;
    ctrl_in    = 9'h101;
    step();
    ctrl_in    = 9'h102;
    step();
    flush_mask = 3'b100;
    ctrl_in    = 9'h103;
    step();
    checks++;
    if (ctrl_out !== {9'h000, 9'h102, 9'h103} || valid_out !== 3'b011) begin
      errors++;
      $display("FAIL flush_stage2 ctrl_out=%h vld=%b want %h 011", ctrl_out,
               valid_out, {9'h000, 9'h102, 9'h103});
    end
  endtask

  task automatic test_hold();
    int bubbles;
    drain();
    valid_in  = 1'b1;
    ctrl_in   = 9'h123;
    hold_load = 1'b1;
    hold_len  = 3'd3;
    step();
    hold_load = 1'b0;
    checks++;
    if (valid_out[0] !== 1'b0 || hold_busy !== 1'b1) begin
      errors++;
      $display("FAIL hold3_edge1 v0=%b busy=%b want 0 1", valid_out[0], hold_busy);
    end
    step();
    checks++;
    if (valid_out[0] !== 1'b0 || hold_busy !== 1'b1) begin
      errors++;
      $display("FAIL hold3_edge2 v0=%b busy=%b want 0 1", valid_out[0], hold_busy);
    end
    step();
    checks++;
    if (valid_out[0] !== 1'b0 || hold_busy !== 1'b0) begin
      errors++;
      $display("FAIL hold3_edge3 v0=%b busy=%b want 0 0", valid_out[0], hold_busy);
    end
    step();
    checks++;
    if (ctrl_out[0 +: 9] !== 9'h123 || valid_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL hold3_after s0=%h v0=%b want 123 1", ctrl_out[0 +: 9], valid_out[0]);
    end

    // Reload with len=2 while counter is 1: exactly 2 further bubbles.
    hold_load = 1'b1;
    hold_len  = 3'd3;
    step();
    hold_load = 1'b0;
    step();
    hold_load = 1'b1;
    hold_len  = 3'd2;
    bubbles   = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      hold_load = 1'b0;
      if (valid_out[0] === 1'b0) bubbles++;
    end
    checks++;
    if (bubbles !== 2) begin
      errors++;
      $display("FAIL hold_reload bubbles=%0d want 2", bubbles);
    end

    // Zero length: no bubble, counter stays idle.
    hold_load = 1'b1;
    hold_len  = 3'd0;
    ctrl_in   = 9'h045;
    step();
    hold_load = 1'b0;
    checks++;
    if (ctrl_out[0 +: 9] !== 9'h045 || valid_out[0] !== 1'b1 || hold_busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_zero s0=%h v0=%b busy=%b want 045 1 0", ctrl_out[0 +: 9],
               valid_out[0], hold_busy);
    end

    // Reset mid-hold abandons the remaining bubbles.
    hold_load = 1'b1;
    hold_len  = 3'd7;
    step();
    hold_load = 1'b0;
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    ctrl_in = 9'h0EE;
    step();
    checks++;
    if (ctrl_out[0 +: 9] !== 9'h0EE || valid_out[0] !== 1'b1 || hold_busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_reset_abandon s0=%h v0=%b busy=%b want 0ee 1 0", ctrl_out[0 +: 9],
               valid_out[0], hold_busy);
    end
  endtask

  task automatic test_bubble_sat();
    drain();
    // Clear wins even though stage 2 is invalid (increment pending).
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (bubble_cnt !== 16'h0) begin
      errors++;
      $display("FAIL cnt_clr_first bubble_cnt=%h want 0000", bubble_cnt);
    end
    repeat (16'hFFFE) step();
    checks++;
    if (bubble_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL cnt_preload bubble_cnt=%h want fffe", bubble_cnt);
    end
    step();
    checks++;
    if (bubble_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_reach_max bubble_cnt=%h want ffff", bubble_cnt);
    end
    step();
    step();
    checks++;
    if (bubble_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_saturate bubble_cnt=%h want ffff", bubble_cnt);
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (bubble_cnt !== 16'h0) begin
      errors++;
      $display("FAIL cnt_clr_wins bubble_cnt=%h want 0000", bubble_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_latency();
    test_reset_mid();
    test_stall();
    test_flush();
    test_hold();
    test_bubble_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_filter.md
CTRL_PIPE_FILTER -- requirements
Module: ctrl_pipe_filter

Interface
REQ-001 SHALL have parameter CW, default 9, meaning control bundle width {Jump, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}.
REQ-002 SHALL have parameter DEPTH, default 3, meaning number of control register stages (ID/EX, EX/MEM, MEM/WB); legal range 2..8.
REQ-003 SHALL have parameter NOP_VALUE, default all-zero CW bits, meaning the bundle written on any bubble.
REQ-004 SHALL have parameter HW, default 3, meaning flush-hold length width.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 ctrl_in  input  CW  decoded control bundle entering stage 0.
REQ-008 valid_in  input  1  ctrl_in carries a real instruction.
REQ-009 stall  input  1  hold stage 0, inject bubble into stage 1.
REQ-010 flush_mask  input  DEPTH  bit k kills the entry entering stage k this edge.
REQ-011 hold_load  input  1  load flush-hold counter from hold_len.
REQ-012 hold_len  input  HW  number of consecutive stage-0 bubbles.
REQ-013 cnt_clr  input  1  synchronous clear of bubble_cnt.
REQ-014 ctrl_out  output  DEPTH*CW  stage k bundle at bits [k*CW +: CW].
REQ-015 valid_out  output  DEPTH  stage k valid.
REQ-016 hold_busy  output  1  flush-hold counter nonzero.
REQ-017 bubble_cnt  output  16  cycles with last stage invalid, saturating.

Function
REQ-018 Bubble SHALL mean valid=0 and bundle=NOP_VALUE; an invalid stage SHALL always present NOP_VALUE on ctrl_out.
REQ-019 Stage 0 next SHALL be, in priority: bubble if flush_mask[0] or hold active; else hold current if stall; else {ctrl_in, valid_in}, with ctrl forced to NOP_VALUE when valid_in=0.
REQ-020 Stage 1 next SHALL be, in priority: bubble if flush_mask[1]; bubble if stall; else stage 0 current.
REQ-021 Stage k>=2 next SHALL be bubble if flush_mask[k], else stage k-1 current; stall SHALL NOT hold stages >=1.
REQ-022 Latency ctrl_in to stage k output SHALL be k+1 rising edges with no stall/flush.
REQ-023 Hold active SHALL mean counter!=0, or hold_load=1 with hold_len!=0 in the same cycle.
REQ-024 On hold_load: counter <= hold_len-1 if hold_len!=0, else 0; load SHALL override any running count (reload, not accumulate); exactly hold_len stage-0 bubbles starting the load cycle.
REQ-025 Without load, nonzero counter SHALL decrement by 1 per edge; hold_busy = (counter!=0), registered.
REQ-026 Flush SHALL win over stall on the same stage; stall during hold SHALL still inject bubble at stage 1 and keep stage 0 a bubble.
REQ-027 bubble_cnt SHALL increment when valid_out[DEPTH-1]=0 at the edge, saturate at 16'hFFFF, and cnt_clr SHALL win over increment (result 0).

Reset
REQ-028 rst_n low SHALL immediately force all stages to bubble, valid_out all 0, counter 0, hold_busy 0, bubble_cnt 0, independent of clk.
REQ-029 First stage load after rst_n deassertion SHALL occur on the first rising edge with rst_n high; reset mid-hold SHALL abandon the hold.

Structure
REQ-030 Shared package ctrl_pkg SHALL hold bundle field offsets, default CW, and NOP_VALUE constant for reuse by decoder and hazard unit.
REQ-031 One sub-module ctrl_stage_reg (CW+1-bit register with load, hold, kill) SHALL be instantiated DEPTH times via generate.
REQ-032 Hold counter and bubble counter SHALL live in the top module; no combinational path from flush_mask to ctrl_out.

Verification (DEPTH=3, CW=9, HW=3)
REQ-033 Assert rst_n=0 mid-stream, no clk edge -> ctrl_out=0, valid_out=3'b000, bubble_cnt=0 immediately.
REQ-034 ctrl_in=9'h1A5, valid_in=1 at edge 0, then valid_in=0 -> stage0 9'h1A5 after edge 1, stage2 9'h1A5 valid after edge 3, then NOP.
REQ-035 Stage0=A(9'h0C3), stall=1 one cycle -> stage0 stays A, stage1 bubble, stage1=A next edge after stall released.
REQ-036 stall=1 with flush_mask=3'b011 -> stage0 and stage1 bubble, stage2 takes previous stage1.
REQ-037 hold_load=1, hold_len=3 -> exactly 3 stage-0 bubbles, hold_busy high 2 cycles; reload hold_len=2 while counter=1 -> 2 further bubbles, not 3.
REQ-038 Preload bubble_cnt to 16'hFFFE via idle cycles -> stays 16'hFFFF; cnt_clr with increment same edge -> 0.
